// File: rtl/regbank_access_ctrl.sv
// Register_Bank initiator: arbitrates decode operand reads and ALU writebacks onto the single bank port.
// Optional build macro HOLD_WB_BYPASS_EN: a drain into HOLD also refreshes matching held operands.
module regbank_access_ctrl #(
   parameter int ARQ = 16,
   parameter int AW  = 3
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [AW-1:0]  req_src1,
   input  logic [AW-1:0]  req_src2,
   input  logic [AW-1:0]  req_dest,
   output logic           op_valid,
   input  logic           op_ready,
   output logic [ARQ-1:0] op_a,
   output logic [ARQ-1:0] op_b,
   output logic [ARQ-1:0] op_c,
   input  logic           wb_valid,
   output logic           wb_ready,
   input  logic [AW-1:0]  wb_dest,
   input  logic [ARQ-1:0] wb_data,
   output logic           rb_writeEn,
   output logic           rb_readEn,
   output logic [AW-1:0]  rb_src1,
   output logic [AW-1:0]  rb_src2,
   output logic [AW-1:0]  rb_srcdest,
   output logic [ARQ-1:0] rb_writeVal,
   input  logic [ARQ-1:0] rb_out1,
   input  logic [ARQ-1:0] rb_out2,
   input  logic [ARQ-1:0] rb_out3
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

   state_t         state_q, state_d;
   logic           wb_full_q, wb_full_d;
   logic [AW-1:0]  wb_dest_q, wb_dest_d;
   logic [ARQ-1:0] wb_data_q, wb_data_d;
   logic           rb_writeEn_q, rb_writeEn_d;
   logic           rb_readEn_q, rb_readEn_d;
   logic [AW-1:0]  rb_src1_q, rb_src1_d;
   logic [AW-1:0]  rb_src2_q, rb_src2_d;
   logic [AW-1:0]  rb_srcdest_q, rb_srcdest_d;
   logic [ARQ-1:0] rb_writeVal_q, rb_writeVal_d;
   logic [ARQ-1:0] op_a_q, op_a_d;
   logic [ARQ-1:0] op_b_q, op_b_d;
   logic [ARQ-1:0] op_c_q, op_c_d;
`ifdef HOLD_WB_BYPASS_EN
   logic [AW-1:0]  rd_dest_q, rd_dest_d;
`endif

   logic req_fire;
   logic wb_fire;
   logic drain;

   // Handshake readiness is forced low while reset is asserted.
   assign req_ready = !rst && (state_q == S_IDLE) && !wb_full_q;
   assign wb_ready  = !rst && !wb_full_q;
   assign req_fire  = req_valid && req_ready;
   assign wb_fire   = wb_valid && wb_ready;

   assign op_valid    = (state_q == S_HOLD);
   assign op_a        = op_a_q;
   assign op_b        = op_b_q;
   assign op_c        = op_c_q;
   assign rb_writeEn  = rb_writeEn_q;
   assign rb_readEn   = rb_readEn_q;
   assign rb_src1     = rb_src1_q;
   assign rb_src2     = rb_src2_q;
   assign rb_srcdest  = rb_srcdest_q;
   assign rb_writeVal = rb_writeVal_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (req_fire) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  state_d = S_HOLD;
         S_HOLD:  if (op_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // The write strobe is registered, so a drain is launched whenever the cycle
   // being entered is IDLE or HOLD; srcdest is then free of the read.
   assign drain = wb_full_q && ((state_d == S_IDLE) || (state_d == S_HOLD));

   always_comb begin
      wb_full_d     = wb_full_q;
      wb_dest_d     = wb_dest_q;
      wb_data_d     = wb_data_q;
      rb_readEn_d   = req_fire;
      rb_writeEn_d  = drain;
      rb_writeVal_d = drain ? wb_data_q : '0;
      rb_src1_d     = rb_src1_q;
      rb_src2_d     = rb_src2_q;
      rb_srcdest_d  = rb_srcdest_q;
      op_a_d        = op_a_q;
      op_b_d        = op_b_q;
      op_c_d        = op_c_q;
`ifdef HOLD_WB_BYPASS_EN
      rd_dest_d     = rd_dest_q;
`endif

      if (drain) begin
         wb_full_d = 1'b0;
      end else if (wb_fire) begin
         wb_full_d = 1'b1;
         wb_dest_d = wb_dest;
         wb_data_d = wb_data;
      end

      if (req_fire) begin
         rb_src1_d    = req_src1;
         rb_src2_d    = req_src2;
         rb_srcdest_d = req_dest;
`ifdef HOLD_WB_BYPASS_EN
         rd_dest_d    = req_dest;
`endif
      end else if (drain) begin
         rb_srcdest_d = wb_dest_q;
      end

      if (state_q == S_WAIT) begin
         op_a_d = rb_out1;
         op_b_d = rb_out2;
         op_c_d = rb_out3;
      end

`ifdef HOLD_WB_BYPASS_EN
      // Overrides the capture too: the bank read predates this write.
      if (drain && (state_d == S_HOLD)) begin
         if (rb_src1_q == wb_dest_q) op_a_d = wb_data_q;
         if (rb_src2_q == wb_dest_q) op_b_d = wb_data_q;
         if (rd_dest_q == wb_dest_q) op_c_d = wb_data_q;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         wb_full_q     <= 1'b0;
         wb_dest_q     <= '0;
         wb_data_q     <= '0;
         rb_writeEn_q  <= 1'b0;
         rb_readEn_q   <= 1'b0;
         rb_src1_q     <= '0;
         rb_src2_q     <= '0;
         rb_srcdest_q  <= '0;
         rb_writeVal_q <= '0;
         op_a_q        <= '0;
         op_b_q        <= '0;
         op_c_q        <= '0;
`ifdef HOLD_WB_BYPASS_EN
         rd_dest_q     <= '0;
`endif
      end else begin
         state_q       <= state_d;
         wb_full_q     <= wb_full_d;
         wb_dest_q     <= wb_dest_d;
         wb_data_q     <= wb_data_d;
         rb_writeEn_q  <= rb_writeEn_d;
         rb_readEn_q   <= rb_readEn_d;
         rb_src1_q     <= rb_src1_d;
         rb_src2_q     <= rb_src2_d;
         rb_srcdest_q  <= rb_srcdest_d;
         rb_writeVal_q <= rb_writeVal_d;
         op_a_q        <= op_a_d;
         op_b_q        <= op_b_d;
         op_c_q        <= op_c_d;
`ifdef HOLD_WB_BYPASS_EN
         rd_dest_q     <= rd_dest_d;
`endif
      end
   end

endmodule

// File: tb/tb_regbank_access_ctrl.sv
// Bench for regbank_access_ctrl: behavioural bank plus register-file reference model, directed then random steps.
// Honours HOLD_WB_BYPASS_EN for the held-operand expectations.
module tb_regbank_access_ctrl;

   localparam int ARQ = 16;
   localparam int AW  = 3;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           req_valid = 1'b0;
   logic           req_ready;
   logic [AW-1:0]  req_src1 = '0, req_src2 = '0, req_dest = '0;
   logic           op_valid;
   logic           op_ready = 1'b0;
   logic [ARQ-1:0] op_a, op_b, op_c;
   logic           wb_valid = 1'b0;
   logic           wb_ready;
   logic [AW-1:0]  wb_dest = '0;
   logic [ARQ-1:0] wb_data = '0;
   logic           rb_writeEn, rb_readEn;
   logic [AW-1:0]  rb_src1, rb_src2, rb_srcdest;
   logic [ARQ-1:0] rb_writeVal;
   logic [ARQ-1:0] rb_out1 = '0, rb_out2 = '0, rb_out3 = '0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [ARQ-1:0] bank_mem [8];
   logic [ARQ-1:0] ref_regs [8];

   always #5 clk = ~clk;

   regbank_access_ctrl #(.ARQ(ARQ), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_src1(req_src1), .req_src2(req_src2), .req_dest(req_dest),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_a(op_a), .op_b(op_b), .op_c(op_c),
      .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_dest(wb_dest), .wb_data(wb_data),
      .rb_writeEn(rb_writeEn), .rb_readEn(rb_readEn),
      .rb_src1(rb_src1), .rb_src2(rb_src2), .rb_srcdest(rb_srcdest),
      .rb_writeVal(rb_writeVal),
      .rb_out1(rb_out1), .rb_out2(rb_out2), .rb_out3(rb_out3)
   );

   // Register_Bank model: write on edge, read sampled on edge, data visible next cycle.
   always @(posedge clk) begin
      if (rb_writeEn) bank_mem[rb_srcdest] <= rb_writeVal;
      if (rb_readEn) begin
         rb_out1 <= bank_mem[rb_src1];
         rb_out2 <= bank_mem[rb_src2];
         rb_out3 <= bank_mem[rb_srcdest];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Port-protocol rules checked every cycle outside reset.
   always @(negedge clk) begin
      if (!rst) begin
         chk("rd_wr_exclusive", {31'd0, rb_writeEn & rb_readEn}, 32'd0);
         chk("writeVal_zero_when_idle", {31'd0, (!rb_writeEn && (rb_writeVal != '0))}, 32'd0);
      end
   end

   task automatic do_wb(input logic [AW-1:0] d, input logic [ARQ-1:0] v);
      int k;
      wb_dest = d; wb_data = v; wb_valid = 1'b1;
      k = 0;
      while (!wb_ready && k < 20) begin tick(); k++; end
      chk("wb_ready_wait", {31'd0, wb_ready}, 32'd1);
      tick();
      wb_valid = 1'b0;
   endtask

   task automatic wait_drain(input logic [AW-1:0] d, input logic [ARQ-1:0] v);
      int k;
      k = 0;
      while (!rb_writeEn && k < 6) begin tick(); k++; end
      chk("drain_writeEn", {31'd0, rb_writeEn}, 32'd1);
      chk("drain_srcdest", {29'd0, rb_srcdest}, {29'd0, d});
      chk("drain_writeVal", {16'd0, rb_writeVal}, {16'd0, v});
      tick();
      chk("drain_one_cycle", {31'd0, rb_writeEn}, 32'd0);
   endtask

   task automatic do_wb_drain(input logic [AW-1:0] d, input logic [ARQ-1:0] v);
      do_wb(d, v);
      wait_drain(d, v);
      ref_regs[d] = v;
   endtask

   task automatic do_read(input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                          input logic [AW-1:0] d, input int stall);
      logic [ARQ-1:0] ea, eb, ec;
      int k;
      ea = ref_regs[s1]; eb = ref_regs[s2]; ec = ref_regs[d];
      req_src1 = s1; req_src2 = s2; req_dest = d; req_valid = 1'b1;
      k = 0;
      while (!req_ready && k < 20) begin tick(); k++; end
      chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
      chk("issue_readEn", {31'd0, rb_readEn}, 32'd1);
      chk("issue_src1", {29'd0, rb_src1}, {29'd0, s1});
      chk("issue_src2", {29'd0, rb_src2}, {29'd0, s2});
      chk("issue_srcdest", {29'd0, rb_srcdest}, {29'd0, d});
      chk("issue_op_valid", {31'd0, op_valid}, 32'd0);
      tick();
      chk("wait_readEn", {31'd0, rb_readEn}, 32'd0);
      chk("wait_op_valid", {31'd0, op_valid}, 32'd0);
      tick();
      chk("hold_op_valid", {31'd0, op_valid}, 32'd1);
      chk("hold_op_a", {16'd0, op_a}, {16'd0, ea});
      chk("hold_op_b", {16'd0, op_b}, {16'd0, eb});
      chk("hold_op_c", {16'd0, op_c}, {16'd0, ec});
      for (int i = 0; i < stall; i++) begin
         tick();
         chk("stall_op_valid", {31'd0, op_valid}, 32'd1);
         chk("stall_op_a", {16'd0, op_a}, {16'd0, ea});
         chk("stall_op_c", {16'd0, op_c}, {16'd0, ec});
         chk("stall_no_read", {31'd0, rb_readEn}, 32'd0);
      end
      op_ready = 1'b1;
      tick();
      op_ready = 1'b0;
      chk("consumed_op_valid", {31'd0, op_valid}, 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: observed still running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [ARQ-1:0] ea, eb, ec, old2;
      logic [AW-1:0]  ra, rb, rc;
      logic [ARQ-1:0] rv;

      for (int i = 0; i < 8; i++) begin
         bank_mem[i] = ARQ'(i * 3 + 5);
         ref_regs[i] = ARQ'(i * 3 + 5);
      end

      // Reset held for five cycles
      #2 rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
         chk("rst_wb_ready", {31'd0, wb_ready}, 32'd0);
         chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
         chk("rst_readEn_writeEn", {30'd0, rb_readEn, rb_writeEn}, 32'd0);
      end
      chk("rst_op_a", {16'd0, op_a}, 32'd0);
      chk("rst_srcdest", {29'd0, rb_srcdest}, 32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("post_rst_wb_ready", {31'd0, wb_ready}, 32'd1);

      // Buffered write then dependent read
      do_wb_drain(3'd1, 16'd150);
      do_read(3'd1, 3'd0, 3'd2, 0);

      // Same-cycle request and writeback: read first, write in first HOLD cycle
      old2 = ref_regs[2];
      eb = ref_regs[1];
      ec = ref_regs[4];
      req_src1 = 3'd2; req_src2 = 3'd1; req_dest = 3'd4; req_valid = 1'b1;
      wb_dest = 3'd2; wb_data = 16'd145; wb_valid = 1'b1;
      chk("same_req_ready", {31'd0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0; wb_valid = 1'b0;
      chk("same_issue_readEn", {31'd0, rb_readEn}, 32'd1);
      chk("same_issue_writeEn", {31'd0, rb_writeEn}, 32'd0);
      chk("same_wb_ready_low", {31'd0, wb_ready}, 32'd0);
      tick();
      chk("same_wait_writeEn", {31'd0, rb_writeEn}, 32'd0);
      tick();
      chk("same_hold_op_valid", {31'd0, op_valid}, 32'd1);
      chk("same_hold_writeEn", {31'd0, rb_writeEn}, 32'd1);
      chk("same_hold_srcdest", {29'd0, rb_srcdest}, 32'd2);
      chk("same_hold_writeVal", {16'd0, rb_writeVal}, 32'd145);
`ifdef HOLD_WB_BYPASS_EN
      ea = 16'd145;
`else
      ea = old2;
`endif
      chk("same_hold_op_a", {16'd0, op_a}, {16'd0, ea});
      chk("same_hold_op_b", {16'd0, op_b}, {16'd0, eb});
      chk("same_hold_op_c", {16'd0, op_c}, {16'd0, ec});
      ref_regs[2] = 16'd145;

      // Back-pressure in HOLD for five cycles
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_op_valid", {31'd0, op_valid}, 32'd1);
         chk("bp_op_a", {16'd0, op_a}, {16'd0, ea});
         chk("bp_op_b", {16'd0, op_b}, {16'd0, eb});
         chk("bp_op_c", {16'd0, op_c}, {16'd0, ec});
         chk("bp_no_read", {31'd0, rb_readEn}, 32'd0);
         chk("bp_no_write", {31'd0, rb_writeEn}, 32'd0);
      end
      op_ready = 1'b1;
      tick();
      op_ready = 1'b0;
      chk("bp_released", {31'd0, op_valid}, 32'd0);

      // Writeback to a held operand's source while in HOLD
      eb = ref_regs[3];
      req_src1 = 3'd1; req_src2 = 3'd3; req_dest = 3'd1; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      chk("byp_hold_op_a", {16'd0, op_a}, 32'd150);
      wb_dest = 3'd1; wb_data = 16'd77; wb_valid = 1'b1;
      tick();
      wb_valid = 1'b0;
      tick();
      chk("byp_writeEn", {31'd0, rb_writeEn}, 32'd1);
      chk("byp_srcdest", {29'd0, rb_srcdest}, 32'd1);
      chk("byp_writeVal", {16'd0, rb_writeVal}, 32'd77);
`ifdef HOLD_WB_BYPASS_EN
      ea = 16'd77;
`else
      ea = 16'd150;
`endif
      chk("byp_op_a", {16'd0, op_a}, {16'd0, ea});
      chk("byp_op_b", {16'd0, op_b}, {16'd0, eb});
      chk("byp_op_c", {16'd0, op_c}, {16'd0, ea});
      chk("byp_op_valid", {31'd0, op_valid}, 32'd1);
      ref_regs[1] = 16'd77;
      op_ready = 1'b1;
      tick();
      op_ready = 1'b0;

      // Reset asserted during ISSUE
      req_src1 = 3'd1; req_src2 = 3'd2; req_dest = 3'd3; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("rstmid_issue_readEn", {31'd0, rb_readEn}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rstmid_readEn", {31'd0, rb_readEn}, 32'd0);
      chk("rstmid_op_valid", {31'd0, op_valid}, 32'd0);
      chk("rstmid_src1", {29'd0, rb_src1}, 32'd0);
      chk("rstmid_op_a", {16'd0, op_a}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      do_read(3'd1, 3'd2, 3'd3, 1);

      // Random mix of writebacks and reads against the register-file model
      for (int it = 0; it < 40; it++) begin
         ra = AW'($urandom_range(0, 7));
         rb = AW'($urandom_range(0, 7));
         rc = AW'($urandom_range(0, 7));
         rv = ARQ'($urandom);
         if ($urandom_range(0, 1) == 0) do_wb_drain(ra, rv);
         else do_read(ra, rb, rc, int'($urandom_range(0, 3)));
      end

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
